// File: rtl/instr_fetch.sv
// Instruction-fetch stage for the single-cycle MIPS core.
// Owns the program counter, fetches one word per issue slot over a ready
// handshake, holds it for the decoder and selects the next PC from the
// decoder's Jump/Branch outputs and the ALU zero flag.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero,
  input  logic        stall,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_retired;
  logic        r_imemReq;
  logic        r_instrValid;

  logic [31:0] w_pcPlus4;
  logic [31:0] w_branchOffset;
  logic [31:0] w_nextPc;

  assign w_pcPlus4      = r_pc + 32'd4;
  assign w_branchOffset = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

  // Next-PC select: jump wins outright so an undefined branch/zero under j cannot leak in.
  always_comb begin
    w_nextPc = w_pcPlus4;
    if (jump) begin
      w_nextPc = {w_pcPlus4[31:28], r_instr[25:0], 2'b00};
    end else if (branch && zero) begin
      w_nextPc = w_pcPlus4 + w_branchOffset;
    end
  end

  // Fetch/issue state machine; the request and valid flags are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_pc         <= {RESET_PC[31:2], 2'b00};
      r_instr      <= 32'd0;
      r_retired    <= 32'd0;
      r_imemReq    <= 1'b0;
      r_instrValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state      <= FETCH;
          r_imemReq    <= 1'b1;
          r_instrValid <= 1'b0;
        end
        FETCH: begin
          if (imem_ready) begin
            r_instr      <= imem_rdata;
            r_state      <= ISSUE;
            r_imemReq    <= 1'b0;
            r_instrValid <= 1'b1;
          end
        end
        ISSUE: begin
          if (!stall) begin
            r_pc         <= w_nextPc;
            r_retired    <= r_retired + 32'd1;
            r_state      <= FETCH;
            r_imemReq    <= 1'b1;
            r_instrValid <= 1'b0;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_imemReq    <= 1'b0;
          r_instrValid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr   = r_pc;
  assign imem_req    = r_imemReq;
  assign instr       = r_instr;
  assign opcode      = r_instr[31:26];
  assign instr_valid = r_instrValid;
  assign pc          = r_pc;
  assign pc_plus4    = w_pcPlus4;
  assign retired     = r_retired;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: expected fetch addresses and fetched
// words are queued when stimulus is driven and compared when the DUT shows them.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        jump;
  logic        branch;
  logic        zero;
  logic        stall;
  logic [31:0] retired;

  int          assertCount;
  int          failCount;
  logic [31:0] expAddrQ[$];
  logic [31:0] expInstrQ[$];
  logic [31:0] modelRetired;
  logic [31:0] lastInstr;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk),
    .reset(reset),
    .imem_addr(imem_addr),
    .imem_req(imem_req),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .instr(instr),
    .opcode(opcode),
    .instr_valid(instr_valid),
    .pc(pc),
    .pc_plus4(pc_plus4),
    .jump(jump),
    .branch(branch),
    .zero(zero),
    .stall(stall),
    .retired(retired)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so a stuck run still ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete fetch/issue slot starting in FETCH, ending in the next FETCH.
  task automatic applyStimulus(input logic [31:0] word, input int waits, input int stalls,
                               input logic j, input logic b, input logic z,
                               input logic [31:0] expNext);
    logic [31:0] a;
    logic [31:0] e;
    a = expAddrQ.pop_front();
    checkOutput("fetchAddr", imem_addr, a);
    checkOutput("fetchReq", {31'd0, imem_req}, 32'd1);
    checkOutput("fetchValid", {31'd0, instr_valid}, 32'd0);
    for (int i = 0; i < waits; i++) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      tick();
      checkOutput("waitAddr", imem_addr, a);
      checkOutput("waitReq", {31'd0, imem_req}, 32'd1);
      checkOutput("waitInstr", instr, lastInstr);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    expInstrQ.push_back(word);
    tick();
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    e = expInstrQ.pop_front();
    lastInstr = e;
    checkOutput("issueInstr", instr, e);
    checkOutput("issueOpcode", {26'd0, opcode}, {26'd0, e[31:26]});
    checkOutput("issueValid", {31'd0, instr_valid}, 32'd1);
    checkOutput("issueReq", {31'd0, imem_req}, 32'd0);
    checkOutput("issuePc", pc, a);
    checkOutput("issuePcPlus4", pc_plus4, a + 32'd4);
    for (int s = 0; s < stalls; s++) begin
      stall      = 1'b1;
      jump       = 1'($urandom);
      branch     = 1'($urandom);
      zero       = 1'($urandom);
      imem_ready = 1'b1;
      imem_rdata = $urandom;
      tick();
      checkOutput("stallValid", {31'd0, instr_valid}, 32'd1);
      checkOutput("stallReq", {31'd0, imem_req}, 32'd0);
      checkOutput("stallPc", pc, a);
      checkOutput("stallInstr", instr, e);
      checkOutput("stallRetired", retired, modelRetired);
    end
    imem_ready = 1'b0;
    stall  = 1'b0;
    jump   = j;
    branch = b;
    zero   = z;
    expAddrQ.push_back(expNext);
    modelRetired = modelRetired + 32'd1;
    tick();
    jump   = 1'b0;
    branch = 1'b0;
    zero   = 1'b0;
    checkOutput("exitRetired", retired, modelRetired);
    checkOutput("exitValid", {31'd0, instr_valid}, 32'd0);
  endtask

  // Reset-value checks shared by power-on and mid-run reset.
  task automatic checkResetState();
    checkOutput("rstPc", pc, 32'h0000_0000);
    checkOutput("rstAddr", imem_addr, 32'h0000_0000);
    checkOutput("rstInstr", instr, 32'h0000_0000);
    checkOutput("rstOpcode", {26'd0, opcode}, 32'd0);
    checkOutput("rstValid", {31'd0, instr_valid}, 32'd0);
    checkOutput("rstReq", {31'd0, imem_req}, 32'd0);
    checkOutput("rstRetired", retired, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    assertCount  = 0;
    failCount    = 0;
    modelRetired = 32'd0;
    lastInstr    = 32'd0;
    reset      = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
    jump       = 1'b0;
    branch     = 1'b0;
    zero       = 1'b0;
    stall      = 1'b0;
    tick();
    tick();
    checkResetState();
    reset = 1'b0;
    expAddrQ.push_back(32'h0000_0000);
    tick();

    // Sequential fetch, stall on the third slot, then a wait-state fetch at 0x10.
    applyStimulus(32'h2008_0001, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0004);
    applyStimulus(32'h2009_0002, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0008);
    applyStimulus(32'h200A_0003, 0, 2, 1'b0, 1'b0, 1'b0, 32'h0000_000C);
    checkOutput("retiredThree", retired, 32'd3);
    applyStimulus(32'h0109_5020, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0010);
    applyStimulus(32'h8D0B_0000, 3, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0014);

    // Jump to 0x20, beq -1 taken and not taken, jump with branch/zero also high.
    applyStimulus(32'h0800_0008, 0, 0, 1'b1, 1'b0, 1'b0, 32'h0000_0020);
    applyStimulus(32'h1000_FFFF, 0, 0, 1'b0, 1'b1, 1'b1, 32'h0000_0020);
    applyStimulus(32'h1000_FFFF, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0024);
    applyStimulus(32'h0800_0000, 0, 0, 1'b1, 1'b1, 1'b1, 32'h0000_0000);

    // Backward branch below zero, then run across the 32-bit wrap.
    applyStimulus(32'h1000_FFFD, 0, 0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
    applyStimulus(32'h012A_5820, 0, 0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC);
    applyStimulus(32'h012A_5822, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);

    // Jump keeping pc_plus4[31:28]=F, with branch/zero undefined.
    applyStimulus(32'h1000_FFFD, 0, 0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
    applyStimulus(32'h0800_0040, 0, 0, 1'b1, 1'bx, 1'bx, 32'hF000_0100);
    applyStimulus(32'h1000_FFFF, 0, 1, 1'b0, 1'b1, 1'b0, 32'hF000_0104);

    // Reset in FETCH with a simultaneous ready: data discarded, no retire.
    a = expAddrQ.pop_front();
    checkOutput("preResetAddr", imem_addr, a);
    reset      = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ready = 1'b0;
    checkResetState();
    reset        = 1'b0;
    modelRetired = 32'd0;
    lastInstr    = 32'd0;
    expAddrQ.push_back(32'h0000_0000);
    tick();
    applyStimulus(32'h2008_0001, 1, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage of the single-cycle MIPS core, directly upstream of the main control decoder. It owns the program counter, requests instructions from instruction memory over a ready handshake, and presents the fetched word with its 6-bit opcode to control and the datapath for one issue slot. It then consumes the decoder's Jump/Branch outputs and the ALU zero flag to pick the next PC.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] forced to 0.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  32  instruction address; always equals pc.
- imem_req  out  1  fetch request; high only in FETCH.
- imem_ready  in  1  memory has valid data on imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  held instruction; feeds register-file and immediate fields.
- opcode  out  6  instr[31:26]; drives the control decoder.
- instr_valid  out  1  high in ISSUE; decoder outputs are meaningful only while this is high.
- pc  out  32  address of the held instruction.
- pc_plus4  out  32  pc + 4, modulo 2^32.
- jump  in  1  Jump from control, sampled in ISSUE.
- branch  in  1  Branch from control, sampled in ISSUE.
- zero  in  1  ALU zero flag, sampled in ISSUE.
- stall  in  1  hold the current issue slot; sampled in ISSUE only.
- retired  out  32  count of completed issue slots.

## Operation
- FSM states: IDLE, FETCH, ISSUE.
- IDLE: entered on reset; moves to FETCH on the next edge unconditionally.
- FETCH: imem_req=1 and imem_addr=pc.
  - Edge with imem_ready=1: instr <= imem_rdata, go to ISSUE.
  - Edge with imem_ready=0: stay in FETCH, address held stable.
- ISSUE: instr_valid=1; instr, pc and opcode are held constant.
  - Edge with stall=1: stay in ISSUE, no PC update, retired unchanged.
  - Edge with stall=0: pc <= next_pc, retired <= retired+1, go to FETCH.
- next_pc priority:
  - jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - else branch=1 and zero=1: pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}.
  - else: pc_plus4.
  - When jump=1, branch is don't-care, because control drives it to x for j.
- All PC arithmetic is 32-bit unsigned and wraps: pc=32'hFFFF_FFFC gives pc_plus4=0. Backward branches use two's-complement addition.
- imem_ready outside FETCH is ignored. An x on branch or zero while jump=1 must not corrupt pc.
- instr is captured only in FETCH; its value persists into FETCH until overwritten.

## Timing
- Reset values: pc=RESET_PC&~3, instr=0, opcode=0, instr_valid=0, imem_req=0, retired=0, state=IDLE.
- Reset asserted mid-FETCH or mid-ISSUE:
  - Takes effect on that edge; imem_req drops in the following cycle.
  - A simultaneous imem_ready is discarded; no retire is counted.
- Minimum throughput is 3 cycles per instruction only for the first one (IDLE → FETCH → ISSUE). Steady state is 2 cycles per instruction (FETCH with immediate ready, then ISSUE).
- Latency: data on imem_rdata at edge N appears on instr/opcode/instr_valid in cycle N+1.
- A redirect decided at the ISSUE exit edge is visible on imem_addr in the very next FETCH cycle; no wrong-path fetch ever occurs.
- retired wraps from 32'hFFFF_FFFF to 0.

## Test plan
- Reset, then sequential fetch: RESET_PC=0, ready always 1 → imem_addr 0, 4, 8 on successive FETCH cycles; instr_valid toggles 0,1,0,1; retired=3 after three ISSUE slots.
- Wait states: ready low for 3 cycles at pc=0x10 → imem_req held high, imem_addr stable at 0x10 for 4 cycles; instr captured only on the ready edge.
- Branch: instr=0x1000FFFF (beq, offset −1) at pc=0x20, branch=1, zero=1 → next pc=0x20. With zero=0 → next pc=0x24.
- Jump: instr=0x08000040 at pc=0x9000_0000, jump=1, branch=x → next pc=0x9000_0100. Also check wrap: pc=0xFFFF_FFFC with no redirect → next pc=0.
- Stall: stall=1 for 2 ISSUE cycles → instr, pc and retired unchanged, imem_req=0 throughout. After release, pc advances exactly once.
- Reset mid-operation: reset asserted in FETCH with imem_ready=1 → next cycle pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, retired=0.
